mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one memory port between the fetch stage (instruction read) and the memory stage (data read/write) for a unified single-port memory.
- Sits between the IF/MEM pipeline stages and the memory model, which uses a valid/status handshake.
- Grants one request at a time. Data has priority; a streak limit prevents fetch starvation.
- A watchdog counter aborts transactions the memory never completes.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch request is pending, before fetch is forced.
- TIMEOUT, 64: cycles a granted transaction may wait for mem_status==2'b10 before it is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  fetch request (read only)
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch read data; valid when i_status==2'b10
- i_status  out  2  00 idle, 01 pending, 10 done (1-cycle), 11 error (1-cycle)
- d_valid  in  1  data request
- d_write  in  1  1=write, 0=read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_rdata  out  32  data read data; valid when d_status==2'b10
- d_status  out  2  same encoding as i_status
- mem_valid  out  1  request to memory
- mem_write  out  1  write enable to memory
- mem_addr  out  32  address to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  memory read data
- mem_status  in  2  10 = transaction complete this cycle; other values = not done
- timeout_err  out  1  1-cycle pulse on abort

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D.
- Requester rule: a requester holds valid and its fields stable until its own status reads 10 or 11. A valid sampled high in a later cycle is a new request.
- IDLE:
  - d_valid with (streak<MAX_D_STREAK or !i_valid) -> GRANT_D.
  - Else if i_valid -> GRANT_I.
  - Request fields are latched into registers on the transition edge.
  - mem_valid/mem_write/mem_addr/mem_wdata are registered outputs.
  - Request seen in cycle t gives mem_valid=1 in cycle t+1.
- GRANT_x:
  - mem_valid=1, driven from the latched fields. mem_write=0 in GRANT_I.
  - On mem_status==2'b10: the granted port's status=10 and rdata=mem_rdata combinationally in that cycle. Next state IDLE; mem_valid=0 in the following cycle.
  - Minimum back-to-back spacing is therefore 1 IDLE cycle.
- Status outputs while not done:
  - The granted port reads 01.
  - A non-granted port with valid=1 reads 01.
  - A port with valid=0 reads 00.
  - rdata is 0 whenever status!=10.
- Streak counter:
  - Increments on each GRANT_D entry taken while i_valid=1, saturating at MAX_D_STREAK.
  - Clears on GRANT_I entry or when i_valid=0 in IDLE.
  - When streak==MAX_D_STREAK and both request, fetch wins.
- Watchdog:
  - Counts cycles in GRANT_x, clears on entry.
  - If it reaches TIMEOUT without completion: granted port status=11 for 1 cycle, timeout_err pulse, mem_valid=0 next cycle, FSM to IDLE.
  - Completion and timeout in the same cycle: completion wins.
- Simultaneous i_valid and d_valid in IDLE: data wins unless the streak limit is hit.
- New requests arriving during a grant are ignored until IDLE.
- Reset (any state, including mid-transaction), all outputs and state:
  - FSM IDLE.
  - mem_valid=0, mem_write=0.
  - mem_addr, mem_wdata = 0.
  - Counters = 0.
  - i_status, d_status = 00; rdata outputs = 0; timeout_err=0.
  - An in-flight transaction is dropped, not replayed.
- Width rules:
  - Streak counter is clog2(MAX_D_STREAK+1) bits.
  - Watchdog is clog2(TIMEOUT+1) bits.
  - No wrap-around is permitted.

Test Plan:
- Fetch alone: i_valid=1, i_addr=0x100; memory done 3 cycles after mem_valid with mem_rdata=0x24020005 -> mem_valid high at t+1, mem_addr=0x100, mem_write=0; i_status=10 and i_rdata=0x24020005 in the done cycle; mem_valid=0 next cycle.
- Collision: i_valid and d_valid (write 0xDEADBEEF to 0x200) asserted in the same cycle -> GRANT_D first with mem_write=1, mem_wdata=0xDEADBEEF; i_status=01 throughout; fetch granted after the data done plus 1 IDLE cycle.
- Starvation: d_valid held with back-to-back requests and i_valid continuously high, MAX_D_STREAK=4 -> exactly 4 data grants, then a fetch grant, then the streak resets to 0.
- Timeout: TIMEOUT=8, memory never returns 10 -> d_status=11 and timeout_err=1 on the 8th GRANT cycle; mem_valid=0 next cycle; a queued fetch is granted afterwards.
- Reset mid-transaction: rst during GRANT_D -> next cycle mem_valid=0, both statuses 00, counters 0; a later request is granted normally.
- Done/timeout tie: mem_status=10 on the TIMEOUT cycle -> status 10, no timeout_err.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and memory port.
// slave = arbiter view, master = pipeline stages plus memory model view.
interface mem_port_arbiter_if;
    logic        i_valid;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [1:0]  i_status;
    logic        d_valid;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic [1:0]  d_status;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_status;
    logic        timeout_err;

    modport slave (
        input  i_valid, i_addr, d_valid, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_status,
        output i_rdata, i_status, d_rdata, d_status,
        output mem_valid, mem_write, mem_addr, mem_wdata, timeout_err
    );

    modport master (
        output i_valid, i_addr, d_valid, d_write, d_addr, d_wdata,
        output mem_rdata, mem_status,
        input  i_rdata, i_status, d_rdata, d_status,
        input  mem_valid, mem_write, mem_addr, mem_wdata, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read) and data (read/write).
// Ports: clk, rst (sync, active-high), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    // Watchdog holds grant cycles already elapsed, so the
    // TIMEOUT-th grant cycle is the one where it equals TIMEOUT-1.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic [WW-1:0] r_wdog;
    logic          r_mem_valid;
    logic          r_mem_write;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;

    logic          w_busy;
    logic          w_done;
    logic          w_tmo;
    logic          w_take_d;
    logic          w_take_i;
    logic [1:0]    w_gstat;

    assign w_busy   = (r_state != IDLE);
    assign w_done   = w_busy && (bus.mem_status == 2'b10);
    // Completion beats a timeout landing on the same cycle.
    assign w_tmo    = w_busy && !w_done && (r_wdog == WD_LAST);
    assign w_take_d = bus.d_valid &&
                      ((r_streak < STREAK_MAX) || !bus.i_valid);
    assign w_take_i = !w_take_d && bus.i_valid;
    assign w_gstat  = w_done ? 2'b10 : (w_tmo ? 2'b11 : 2'b01);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_wdog      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!bus.i_valid) r_streak <= '0;
                    if (w_take_d) begin
                        r_state     <= GRANT_D;
                        r_wdog      <= '0;
                        r_mem_valid <= 1'b1;
                        r_mem_write <= bus.d_write;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        if (bus.i_valid && (r_streak != STREAK_MAX))
                            r_streak <= r_streak + SW'(1);
                    end else if (w_take_i) begin
                        r_state     <= GRANT_I;
                        r_wdog      <= '0;
                        r_streak    <= '0;
                        r_mem_valid <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= bus.i_addr;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (w_done || w_tmo) begin
                        r_state     <= IDLE;
                        r_mem_valid <= 1'b0;
                        r_mem_write <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_valid   = r_mem_valid;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.timeout_err = w_tmo && !rst;

    // Status and read data are combinational so the done cycle of the
    // memory is visible to the requester in the same cycle.
    always_comb begin
        bus.i_status = 2'b00;
        bus.d_status = 2'b00;
        bus.i_rdata  = '0;
        bus.d_rdata  = '0;
        if (!rst) begin
            if (r_state == GRANT_I) bus.i_status = w_gstat;
            else if (bus.i_valid)   bus.i_status = 2'b01;
            if (r_state == GRANT_D) bus.d_status = w_gstat;
            else if (bus.d_valid)   bus.d_status = 2'b01;
            if (r_state == GRANT_I && w_done) bus.i_rdata = bus.mem_rdata;
            if (r_state == GRANT_D && w_done) bus.d_rdata = bus.mem_rdata;
        end
    end
endmodule
